// File: rtl/ysyx_23060180_lsu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060180_lsu
// Brief    : RV32 load/store unit. Accepts one load/store per handshake,
//            drives a word-addressed memory bus with byte-lane masks, waits
//            for grant / read data, and returns one response per request
//            with extended load data, echoed rd, or an error flag.
// Option   : YSYX_23060180_LSU_MISALIGN_TRAP_EN -- when defined, misaligned
//            half/word accesses are rejected with resp_err; when undefined
//            they proceed with the address forced to natural alignment.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060180_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn_in,
  // request from execute stage
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  // response to the core
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  // data memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Last count value before the access is abandoned.
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_func3;
  logic [1:0]  r_off;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;

  logic        w_is_half;
  logic        w_is_word;
  logic        w_func3_ok;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_accept_err;
  logic        w_timeout;
  logic [1:0]  w_off;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load_data;

  assign w_accept     = req_valid && req_ready;
  assign w_accept_err = !w_func3_ok || w_misaligned;
  // Compare with >= so a load that is granted on the last allowed REQ cycle
  // still times out in WAIT instead of wrapping the counter.
  assign w_timeout    = (r_cnt >= c_timeout_last);

  // Decode the incoming request: legality, alignment, lane offset and store lanes
  always_comb begin
    w_is_half = (req_func3[1:0] == 2'b01);
    w_is_word = (req_func3[1:0] == 2'b10);

    // Stores: only SB/SH/SW. Loads: LB/LH/LW/LBU/LHU.
    if (req_we) begin
      w_func3_ok = (req_func3[2] == 1'b0) && (req_func3[1:0] != 2'b11);
    end else begin
      w_func3_ok = (req_func3 != 3'b011) && (req_func3[2:1] != 2'b11);
    end

`ifdef YSYX_23060180_LSU_MISALIGN_TRAP_EN
    w_misaligned = (w_is_half && req_addr[0]) ||
                   (w_is_word && (req_addr[1:0] != 2'b00));
`else
    w_misaligned = 1'b0;
`endif

    // Byte offset forced to natural alignment; identical to addr[1:0] for
    // every aligned access, so it is also correct in the trapping build.
    if (w_is_word) begin
      w_off = 2'b00;
    end else if (w_is_half) begin
      w_off = {req_addr[1], 1'b0};
    end else begin
      w_off = req_addr[1:0];
    end

    case (req_func3[1:0])
      2'b00: begin
        w_wmask = 4'b0001 << w_off;
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_wmask = 4'b0011 << w_off;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_wmask = 4'hF;
        w_wdata = req_wdata;
      end
    endcase
  end

  // Select the addressed lane of the read word and extend it per funct3
  always_comb begin
    w_lane = mem_rdata >> {r_off, 3'b000};
    case (r_func3)
      3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_data = {24'd0, w_lane[7:0]};
      3'b101:  w_load_data = {16'd0, w_lane[15:0]};
      default: w_load_data = w_lane;
    endcase
  end

  // Access sequencer: owns the state and registers every bus and response output
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      r_state    <= S_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_rd    <= 5'd0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wmask  <= 4'd0;
      r_we       <= 1'b0;
      r_func3    <= 3'd0;
      r_off      <= 2'd0;
      r_rd       <= 5'd0;
      r_cnt      <= 8'd0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            req_ready <= 1'b0;
            r_we      <= req_we;
            r_func3   <= req_func3;
            r_off     <= w_off;
            r_rd      <= req_rd;
            r_cnt     <= 8'd0;
            if (w_accept_err) begin
              // Rejected before touching the bus.
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              resp_rd    <= req_we ? 5'd0 : req_rd;
            end else begin
              r_state   <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_we ? w_wdata : 32'd0;
              mem_wmask <= req_we ? w_wmask : 4'd0;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
            if (r_we) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'd0;
              resp_rd    <= 5'd0;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= r_cnt + 8'd1;
            end
          end else if (w_timeout) begin
            // Grant never came: withdraw the request and report an error.
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wmask  <= 4'd0;
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
            resp_rd    <= r_we ? 5'd0 : r_rd;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_WAIT: begin
          if (mem_rvalid) begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= w_load_data;
            resp_rd    <= r_rd;
          end else if (w_timeout) begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
            resp_rd    <= r_rd;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_RESP: begin
          // Response was presented for exactly this cycle; reopen for requests.
          r_state    <= S_IDLE;
          req_ready  <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          resp_rd    <= 5'd0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060180_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060180_lsu
// Brief    : Self-checking bench for ysyx_23060180_lsu. Directed cases plus
//            randomized loads/stores against a byte-level reference model,
//            with a bus responder that inserts grant/read-data stalls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060180_lsu;

  localparam int c_to = 255;

  logic        clk;
  logic        rstn_in;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_vec;
  int n_err;

  ysyx_23060180_lsu #(.TIMEOUT_CYCLES(c_to)) dut (
    .clk        (clk),
    .rstn_in    (rstn_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction: reference model, drive, bus responder, checks.
  // gst = cycles mem_gnt is withheld in REQ, rst = cycles mem_rvalid is withheld in WAIT.
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] word, input int gst, input int rst);
    bit          legal, mis, acc_err, tmo, e_err;
    int          size, off, e_lat, e_reqc;
    longint      lowmask, v;
    logic [31:0] e_rdata, e_wdata, e_addr;
    logic [3:0]  e_mask;
    logic [4:0]  e_rd;
    int          cyc, reqc, waitc;
    bit          got, seen_req, granted, unstable;
    logic [31:0] f_addr, f_wdata;
    logic [3:0]  f_mask;
    logic        f_we;

    // ---- reference model: byte-level view of the access ----
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
`ifdef YSYX_23060180_LSU_MISALIGN_TRAP_EN
    mis = legal && ((int'(addr[1:0]) % size) != 0);
`else
    mis = 1'b0;
`endif
    acc_err = !legal || mis;
    off     = (size >= 4) ? 0 : (int'(addr[1:0]) / size) * size;
    lowmask = (64'd1 << (8 * size)) - 64'd1;
    e_addr  = addr & 32'hFFFF_FFFC;
    e_mask  = we ? 4'(((1 << size) - 1) << off) : 4'd0;
    e_wdata = 32'd0;
    if (size <= 4) begin
      for (int k = 0; k < 4 / size; k++) begin
        e_wdata = e_wdata | 32'((longint'(wdata) & lowmask) << (8 * size * k));
      end
    end
    v = (longint'(word) >> (8 * off)) & lowmask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v - (64'd1 << (8 * size));
    tmo = !acc_err && (we ? (gst + 1 > c_to) : (gst + 1 + rst + 1 > c_to));
    e_err   = acc_err || tmo;
    e_rdata = (e_err || we) ? 32'd0 : v[31:0];
    e_rd    = we ? 5'd0 : rd;
    if (acc_err)  e_lat = 1;
    else if (tmo) e_lat = 1 + c_to;
    else if (we)  e_lat = 2 + gst;
    else          e_lat = 3 + gst + rst;
    e_reqc = acc_err ? 0 : ((gst + 1 > c_to) ? c_to : gst + 1);

    // ---- issue the request ----
    for (int i = 0; i < 10; i++) begin
      if (!req_ready) begin
        @(posedge clk); #1;
      end
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    cyc = 1; reqc = 0; waitc = 0;
    got = 0; seen_req = 0; granted = 0; unstable = 0;
    f_addr = '0; f_wdata = '0; f_mask = '0; f_we = 1'b0;

    // ---- bus responder, bounded ----
    while (!got && cyc < 400) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (resp_valid) begin
        got = 1;
      end else begin
        if (mem_req) begin
          if (!seen_req) begin
            f_addr = mem_addr; f_wdata = mem_wdata; f_mask = mem_wmask; f_we = mem_we;
          end else if (mem_addr !== f_addr || mem_wdata !== f_wdata ||
                       mem_wmask !== f_mask || mem_we !== f_we) begin
            unstable = 1;
          end
          seen_req = 1;
          if (reqc == gst) begin
            mem_gnt = 1'b1;
            if (!we) granted = 1;
          end else begin
            mem_rvalid = 1'($urandom_range(0, 1));   // must be ignored in REQ
          end
          reqc++;
        end else if (granted) begin
          if (waitc == rst) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word;
          end else begin
            mem_gnt = 1'($urandom_range(0, 1));      // must be ignored in WAIT
          end
          waitc++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;

    // ---- compare against the model ----
    check("resp_seen", {31'd0, got}, 32'd1);
    check("latency", 32'(cyc), 32'(e_lat));
    check("resp_err", {31'd0, resp_err}, {31'd0, e_err});
    check("resp_rdata", resp_rdata, e_rdata);
    if (!e_err) check("resp_rd", {27'd0, resp_rd}, {27'd0, e_rd});
    check("mem_req_at_resp", {31'd0, mem_req}, 32'd0);
    check("req_cycles", 32'(reqc), 32'(e_reqc));
    if (!acc_err) begin
      check("mem_addr", f_addr, e_addr);
      check("mem_we", {31'd0, f_we}, {31'd0, we});
      check("mem_wmask", {28'd0, f_mask}, {28'd0, e_mask});
      if (we) check("mem_wdata", f_wdata, e_wdata);
      check("bus_stable", {31'd0, unstable}, 32'd0);
    end
    @(posedge clk); #1;
    check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    check("ready_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rstn_in = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rstn_in = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", {31'd0, req_ready}, 32'd1);

    // ---- directed cases ----
    run_txn(1'b0, 3'b010, 32'h8000_0004, 32'd0, 5'd7,  32'hDEAD_BEEF, 0, 0); // LW
    run_txn(1'b0, 3'b000, 32'h8000_0003, 32'd0, 5'd3,  32'h8011_2233, 0, 0); // LB
    run_txn(1'b0, 3'b100, 32'h8000_0003, 32'd0, 5'd4,  32'h8011_2233, 0, 0); // LBU
    run_txn(1'b0, 3'b101, 32'h8000_0002, 32'd0, 5'd5,  32'h8011_2233, 0, 0); // LHU
    run_txn(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 5'd9, 32'd0, 0, 0);  // SB
    run_txn(1'b1, 3'b010, 32'h8000_0010, 32'h1234_5678, 5'd1, 32'd0, 3, 0);  // SW, 3 stalls
    run_txn(1'b1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D, 5'd1, 32'd0, 1000, 0); // grant timeout
    run_txn(1'b0, 3'b010, 32'h8000_0024, 32'd0, 5'd2, 32'h0, 2, 1000);       // rvalid timeout
    run_txn(1'b0, 3'b001, 32'h8000_0001, 32'd0, 5'd6,  32'h1234_8765, 0, 0); // LH misaligned
    run_txn(1'b0, 3'b011, 32'h8000_0000, 32'd0, 5'd8,  32'h0, 0, 0);         // illegal load
    run_txn(1'b1, 3'b100, 32'h8000_0000, 32'h5, 5'd8,  32'h0, 0, 0);         // illegal store
    run_txn(1'b1, 3'b001, 32'h8000_0006, 32'h0000_BEEF, 5'd8, 32'h0, 1, 0);  // SH upper half

    // ---- reset asserted while waiting for read data ----
    check("rw_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010;
    req_addr = 32'h8000_0040; req_rd = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rw_mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #2 rstn_in = 1'b0;
    #1;
    check("rw_async_mem_req", {31'd0, mem_req}, 32'd0);
    check("rw_async_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rw_async_req_ready", {31'd0, req_ready}, 32'd0);
    check("rw_async_mem_addr", mem_addr, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    rstn_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("rw_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    mem_rvalid = 1'b0;
    check("rw_ready_again", {31'd0, req_ready}, 32'd1);
    run_txn(1'b0, 3'b010, 32'h8000_0044, 32'd0, 5'd12, 32'h0BAD_F00D, 0, 0);

    // ---- randomized traffic ----
    for (int t = 0; t < 150; t++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom,
              5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
